// File: rtl/toffoli_cascade_undo.sv
// Reversible register driven by generalised Toffoli gates, with a LIFO gate log
// replayed in reverse to uncompute. Define TOFFOLI_UNDO_CHECK_EN to add the restore checker.
module toffoli_cascade_undo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int TW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             gate_valid,
  output logic             gate_ready,
  input  logic [WIDTH-1:0] gate_mask,
  input  logic [TW-1:0]    gate_tgt,
  input  logic             undo_req,
  output logic [WIDTH-1:0] state_out,
  output logic [CW-1:0]    depth,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             mismatch
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, UNDO, DONE} fsm_t;

  typedef struct packed {
    logic [WIDTH-1:0] mask;
    logic [TW-1:0]    tgt;
  } gate_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  gate_t            log_q [DEPTH];
  gate_t            log_d [DEPTH];
  logic [CW-1:0]    depth_dec;
  gate_t            top_gate;

  // Self-inverse: the target flips only when every control line (target excluded) is 1.
  function automatic logic [WIDTH-1:0] apply_gate(input logic [WIDTH-1:0] s, input gate_t g);
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] r;
    r = s;
    m = g.mask;
    if (int'(g.tgt) < WIDTH) begin
      m[g.tgt] = 1'b0;
      r[g.tgt] = s[g.tgt] ^ (&(s | ~m));
    end
    return r;
  endfunction

  assign depth_dec  = depth_q - CW'(1);
  assign top_gate   = log_q[depth_dec[AW-1:0]];
  assign gate_ready = (fsm_q == IDLE) && !load_valid && !undo_req && (int'(depth_q) < DEPTH);

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    depth_d    = depth_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    log_d      = log_q;
    case (fsm_q)
      IDLE: begin
        if (load_valid) begin
          state_d = load_data;
          depth_d = '0;
        end else if (undo_req) begin
          if (depth_q != '0) begin
            fsm_d  = UNDO;
            busy_d = 1'b1;
          end else begin
            fsm_d  = DONE;
            done_d = 1'b1;
          end
        end else if (gate_valid) begin
          // Without load/undo the only way gate_ready is low here is a full log.
          if (gate_ready) begin
            state_d                 = apply_gate(state_q, {gate_mask, gate_tgt});
            log_d[depth_q[AW-1:0]]  = {gate_mask, gate_tgt};
            depth_d                 = depth_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      UNDO: begin
        state_d = apply_gate(state_q, top_gate);
        depth_d = depth_dec;
        if (depth_dec == '0) begin
          fsm_d  = DONE;
          done_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      depth_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      depth_q    <= depth_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    log_q <= log_d;
  end

  assign state_out = state_q;
  assign depth     = depth_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

`ifdef TOFFOLI_UNDO_CHECK_EN
  logic [WIDTH-1:0] snapshot_q, snapshot_d;
  logic             mismatch_q, mismatch_d;

  // The verdict is computed on the edge entering DONE so it is valid during the done pulse.
  always_comb begin
    snapshot_d = snapshot_q;
    mismatch_d = mismatch_q;
    if (fsm_q == IDLE && load_valid) begin
      snapshot_d = load_data;
      mismatch_d = 1'b0;
    end else if (fsm_q == IDLE && undo_req) begin
      mismatch_d = 1'b0;
    end
    if (fsm_d == DONE && fsm_q != DONE) begin
      mismatch_d = (state_d != snapshot_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      snapshot_q <= snapshot_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: doc/toffoli_cascade_undo.md
Name: toffoli_cascade_undo

Overview:
- Sequential reversible-logic executor holding a WIDTH-bit register.
- Applies a stream of generalised Toffoli gates and logs each gate in a LIFO.
- On request, replays the logged gates in reverse order (uncompute direction), restoring the register to its pre-cascade value.
- Used by the reversible ALU datapath to clear ancilla/garbage lines after a forward computation.

Parameters:
- WIDTH, 4, register width in lines; target index width TW = $clog2(WIDTH).
- DEPTH, 8, gate-log capacity in entries; count width CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load register and clear gate log.
- load_data  in  WIDTH  value for load.
- gate_valid  in  1  gate offered.
- gate_ready  out  1  gate accepted when gate_valid & gate_ready.
- gate_mask  in  WIDTH  control-line mask.
- gate_tgt  in  TW  target line index.
- undo_req  in  1  start reverse replay.
- state_out  out  WIDTH  current register value.
- depth  out  CW  number of logged gates.
- busy  out  1  high while in UNDO.
- done  out  1  one-cycle pulse at end of replay.
- overflow  out  1  sticky; gate offered while log full.

Behaviour:
- Reset values: state_out=0, depth=0, busy=0, done=0, overflow=0, FSM=IDLE.
- Reset mid-UNDO aborts the replay; all outputs return to reset values on the next edge.
- Gate semantics: effective mask m = gate_mask with bit gate_tgt cleared. state[tgt] ^= &(state | ~m); all other bits unchanged. An empty mask makes the gate a NOT on the target line. gate_tgt >= WIDTH makes the gate a no-op that is still logged.
- FSM states: IDLE, UNDO, DONE.
- IDLE priority: load_valid > undo_req > gate.
  - load_valid: state<=load_data, depth<=0. overflow is not cleared.
  - undo_req with depth>0: go to UNDO.
  - undo_req with depth==0: go to DONE directly.
  - Gate accepted: applied and pushed in the same edge, depth+1. state_out reflects the gate on the cycle after acceptance.
- gate_ready = (FSM==IDLE) & !load_valid & !undo_req & (depth<DEPTH). Combinational from inputs; there is no combinational path from gate_valid.
- Full log: gate_valid & (depth==DEPTH) in IDLE without load/undo sets overflow. The gate is neither applied nor logged.
- UNDO:
  - busy=1.
  - Each cycle, pop the top entry, apply it to state, depth-1.
  - When the pop takes depth to 0, go to DONE.
  - Latency is exactly depth-at-start cycles.
  - load_valid, gate_valid and undo_req are ignored in UNDO.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Since each gate is self-inverse, after done state_out equals its value before the first logged gate.
- overflow clears only on rst.

Optional Feature:
- Macro: TOFFOLI_UNDO_CHECK_EN.
- When defined:
  - Adds output mismatch (1 bit).
  - A snapshot register captures load_data on every load.
  - In the DONE cycle, mismatch = (state_out != snapshot). It is held until the next load, undo_req or rst, and reset value is 0.
- When undefined: no snapshot register; mismatch is tied to 0.

Test Plan:
- Single gate: rst; load 4'b0111; gate mask 0111 tgt 3 → state 4'b1111, depth 1; undo → busy 1 cycle, state 4'b0111, done pulse, depth 0.
- Reverse order: load 4'b0111; gate (0111,3) → 1111; gate (1001,1) → 1101; undo → 1111 after cycle 1, 0111 after cycle 2, then done. With CHECK_EN, mismatch=0.
- Full log: DEPTH=8; load 0; push 8 NOT gates (mask 0, tgt 0); state bit0=0, depth 8, gate_ready 0; 9th gate_valid → overflow=1, state and depth unchanged; undo takes 8 busy cycles.
- Empty undo and priority: load 4'b1010; undo_req with depth 0 → done the next cycle, no busy. load_valid, undo_req and gate_valid together → load wins, gate_ready 0, depth 0.
- Reset mid-undo: push 3 gates; undo; assert rst during the 2nd UNDO cycle → next cycle state 0, depth 0, busy 0, no done pulse, overflow 0.
- Ignored inputs in UNDO: during UNDO, drive load_valid=1 with load_data 4'b1111 and gate_valid=1 → gate_ready 0; replay completes to the original value.
